// File: rtl/safebox_lock_ctrl.sv
// rtl/safebox_lock_ctrl.sv - safe-box lock FSM: password check, fail counting, timed lockout, auto-relock, password edit
module safebox_lock_ctrl #(
  parameter int N_DIGITS                      = 4,
  parameter int DIGIT_W                       = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_PW = '0,
  parameter int MAX_FAIL                      = 3,
  parameter int LOCKOUT_CYCLES                = 50_000_000,
  parameter int RELOCK_CYCLES                 = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             open_close,
  input  logic                             set_pw,
  input  logic                             confirm_pw,
  input  logic                             clear_pw,
  input  logic [N_DIGITS*DIGIT_W-1:0]      pw_in,
  output logic                             opened,
  output logic                             show_pw,
  output logic                             alarm,
  output logic                             locked_out,
  output logic                             clean_input,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int PW_W   = N_DIGITS * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LT_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int RT_W   = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
  localparam bit RELOCK_EN = (RELOCK_CYCLES > 0);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
  localparam logic [LT_W-1:0]   LT_LOAD  = LT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [RT_W-1:0]   RT_LAST  = RT_W'((RELOCK_CYCLES > 0) ? RELOCK_CYCLES - 1 : 0);

  // State bits double as registered outputs: [2]=show_pw, [1]=opened, [0]=locked_out.
  typedef enum logic [2:0] {
    S_LOCKED  = 3'b000,
    S_LOCKOUT = 3'b001,
    S_OPEN    = 3'b010,
    S_SETPW   = 3'b110
  } state_t;

  state_t            r_state;
  logic [PW_W-1:0]   r_pw;
  logic [FAIL_W-1:0] r_fail;
  logic [LT_W-1:0]   r_lock_tmr;
  logic [RT_W-1:0]   r_idle;
  logic              r_alarm;
  logic              r_clean;

  logic              w_do_oc;
  logic              w_do_clr;
  logic              w_do_cfm;
  logic              w_do_set;
  logic              w_any;
  logic              w_pw_ok;
  logic              w_relock;
  logic [FAIL_W-1:0] w_fail_nxt;

  assign w_do_oc    = open_close;
  assign w_do_clr   = clear_pw & ~open_close;
  assign w_do_cfm   = confirm_pw & ~open_close & ~clear_pw;
  assign w_do_set   = set_pw & ~open_close & ~clear_pw & ~confirm_pw;
  assign w_any      = open_close | clear_pw | confirm_pw | set_pw;
  assign w_pw_ok    = (pw_in == r_pw);
  assign w_relock   = RELOCK_EN && !w_any && (r_idle == RT_LAST);
  assign w_fail_nxt = (r_fail == FAIL_MAX) ? r_fail : r_fail + FAIL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOCKED;
      r_pw       <= DEFAULT_PW;
      r_fail     <= '0;
      r_lock_tmr <= '0;
      r_idle     <= '0;
      r_alarm    <= 1'b0;
      r_clean    <= 1'b0;
    end else begin
      r_clean <= 1'b0;
      case (r_state)
        S_LOCKED: begin
          if (w_do_oc) begin
            r_clean <= 1'b1;
            if (w_pw_ok) begin
              r_state <= S_OPEN;
              r_alarm <= 1'b0;
              r_fail  <= '0;
              r_idle  <= '0;
            end else begin
              r_alarm <= 1'b1;
              r_fail  <= w_fail_nxt;
              if (w_fail_nxt == FAIL_MAX) begin
                r_state    <= S_LOCKOUT;
                r_lock_tmr <= LT_LOAD;
              end
            end
          end
        end
        S_LOCKOUT: begin
          if (r_lock_tmr == '0) begin
            r_state <= S_LOCKED;
            r_fail  <= '0;
            r_alarm <= 1'b0;
          end else begin
            r_lock_tmr <= r_lock_tmr - LT_W'(1);
          end
        end
        S_OPEN: begin
          if (w_any || !RELOCK_EN) r_idle <= '0;
          else                     r_idle <= r_idle + RT_W'(1);
          if (w_do_oc) begin
            r_state <= S_LOCKED;
            r_clean <= 1'b1;
          end else if (w_do_clr) begin
            r_pw <= DEFAULT_PW;
          end else if (w_do_set) begin
            r_state <= S_SETPW;
            r_clean <= 1'b1;
          end else if (w_relock) begin
            r_state <= S_LOCKED;
            r_clean <= 1'b1;
          end
        end
        S_SETPW: begin
          if (w_do_oc) begin
            r_state <= S_LOCKED;
            r_clean <= 1'b1;
          end else if (w_do_clr) begin
            r_pw    <= DEFAULT_PW;
            r_state <= S_OPEN;
            r_idle  <= '0;
            r_clean <= 1'b1;
          end else if (w_do_cfm) begin
            r_pw    <= pw_in;
            r_state <= S_OPEN;
            r_idle  <= '0;
            r_clean <= 1'b1;
          end
        end
        default: r_state <= S_LOCKED;
      endcase
    end
  end

  assign show_pw     = r_state[2];
  assign opened      = r_state[1];
  assign locked_out  = r_state[0];
  assign alarm       = r_alarm;
  assign clean_input = r_clean;
  assign fail_cnt    = r_fail;

endmodule

// File: tb/tb_safebox_lock_ctrl.sv
// tb/tb_safebox_lock_ctrl.sv - scoreboard bench for safebox_lock_ctrl, two instances (no relock / relock after 10)
module tb_safebox_lock_ctrl;

  localparam int LOCK_C = 20;
  localparam int REL_C  = 10;
  localparam int MAXF   = 3;

  localparam int M_LOCKED  = 0;
  localparam int M_LOCKOUT = 1;
  localparam int M_OPEN    = 2;
  localparam int M_SETPW   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        open_close = 1'b0;
  logic        set_pw = 1'b0;
  logic        confirm_pw = 1'b0;
  logic        clear_pw = 1'b0;
  logic [15:0] pw_in = 16'h0000;

  logic       a_opened, a_show, a_alarm, a_lo, a_clean;
  logic [1:0] a_fail;
  logic       b_opened, b_show, b_alarm, b_lo, b_clean;
  logic [1:0] b_fail;

  safebox_lock_ctrl #(.N_DIGITS(4), .DIGIT_W(4), .DEFAULT_PW(16'h0000), .MAX_FAIL(MAXF),
                      .LOCKOUT_CYCLES(LOCK_C), .RELOCK_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .open_close(open_close), .set_pw(set_pw),
    .confirm_pw(confirm_pw), .clear_pw(clear_pw), .pw_in(pw_in),
    .opened(a_opened), .show_pw(a_show), .alarm(a_alarm), .locked_out(a_lo),
    .clean_input(a_clean), .fail_cnt(a_fail));

  safebox_lock_ctrl #(.N_DIGITS(4), .DIGIT_W(4), .DEFAULT_PW(16'h0000), .MAX_FAIL(MAXF),
                      .LOCKOUT_CYCLES(LOCK_C), .RELOCK_CYCLES(REL_C)) dut_b (
    .clk(clk), .rst(rst), .open_close(open_close), .set_pw(set_pw),
    .confirm_pw(confirm_pw), .clear_pw(clear_pw), .pw_in(pw_in),
    .opened(b_opened), .show_pw(b_show), .alarm(b_alarm), .locked_out(b_lo),
    .clean_input(b_clean), .fail_cnt(b_fail));

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    logic [15:0] pw;
    int          fails;
    bit          alarm;
    bit          clean;
    int          lock_el;
    int          idle;
  } mdl_t;

  mdl_t       ma, mb;
  logic [6:0] qa[$];
  logic [6:0] qb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  event       chk_ev;

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.mode = M_LOCKED; s.pw = 16'h0000; s.fails = 0; s.alarm = 1'b0;
    s.clean = 1'b0; s.lock_el = 0; s.idle = 0;
    return s;
  endfunction

  // Elapsed-cycle counters: lockout lasts LOCK_C cycles, relock fires after `relock` idle cycles.
  function automatic mdl_t mdl_step(input mdl_t s, input int relock, input logic oc, clr, cfm, sp,
                                    input logic [15:0] pw);
    mdl_t n = s;
    int top = oc ? 1 : clr ? 2 : cfm ? 3 : sp ? 4 : 0;
    n.clean = 1'b0;
    case (s.mode)
      M_LOCKED: if (top == 1) begin
        n.clean = 1'b1;
        if (pw == s.pw) begin
          n.mode = M_OPEN; n.alarm = 1'b0; n.fails = 0; n.idle = 0;
        end else begin
          n.alarm = 1'b1;
          n.fails = (s.fails + 1 > MAXF) ? MAXF : s.fails + 1;
          if (n.fails == MAXF) begin n.mode = M_LOCKOUT; n.lock_el = 0; end
        end
      end
      M_LOCKOUT: begin
        n.lock_el = s.lock_el + 1;
        if (n.lock_el == LOCK_C) begin n.mode = M_LOCKED; n.fails = 0; n.alarm = 1'b0; end
      end
      M_OPEN: begin
        n.idle = (top != 0) ? 0 : s.idle + 1;
        if (top == 1) begin n.mode = M_LOCKED; n.clean = 1'b1; end
        else if (top == 2) n.pw = 16'h0000;
        else if (top == 4) begin n.mode = M_SETPW; n.clean = 1'b1; end
        else if (relock > 0 && n.idle == relock) begin n.mode = M_LOCKED; n.clean = 1'b1; end
      end
      default: begin
        if (top == 1) begin n.mode = M_LOCKED; n.clean = 1'b1; end
        else if (top == 2) begin n.pw = 16'h0000; n.mode = M_OPEN; n.idle = 0; n.clean = 1'b1; end
        else if (top == 3) begin n.pw = pw; n.mode = M_OPEN; n.idle = 0; n.clean = 1'b1; end
      end
    endcase
    return n;
  endfunction

  function automatic logic [6:0] expect_of(input mdl_t s);
    logic [1:0] f = 2'(s.fails);
    return {(s.mode == M_OPEN || s.mode == M_SETPW), (s.mode == M_SETPW), s.alarm,
            (s.mode == M_LOCKOUT), s.clean, f};
  endfunction

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got{op,show,alm,lo,clean,fail}=%b expected=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic cycle(input logic r, oc, clr, cfm, sp, input logic [15:0] pw);
    @(negedge clk);
    rst = r; open_close = oc; clear_pw = clr; confirm_pw = cfm; set_pw = sp; pw_in = pw;
    if (r) begin
      ma = mdl_reset(); mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, 0, oc, clr, cfm, sp, pw);
      mb = mdl_step(mb, REL_C, oc, clr, cfm, sp, pw);
    end
    qa.push_back(expect_of(ma));
    qb.push_back(expect_of(mb));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2;
    rst = 1'b1; open_close = 1'b0; clear_pw = 1'b0; confirm_pw = 1'b0; set_pw = 1'b0;
    ma = mdl_reset(); mb = mdl_reset();
    qa.push_back(expect_of(ma));
    qb.push_back(expect_of(mb));
    -> chk_ev;
  endtask

  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      cyc++;
      if (qa.size() > 0) check("dut_norelock", {a_opened, a_show, a_alarm, a_lo, a_clean, a_fail}, qa.pop_front());
      if (qb.size() > 0) check("dut_relock10", {b_opened, b_show, b_alarm, b_lo, b_clean, b_fail}, qb.pop_front());
    end
  end

  initial begin
    ma = mdl_reset(); mb = mdl_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    // open with default, close
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    // edit password to 1234, wrong then right attempt
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    // three wrong opens, ignored correct open during lockout, then recover
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    idle(25);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    // auto-relock after 10 idle cycles (relock instance only)
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    idle(12);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    // set_pw at cycle 5 blocks relock
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle(4);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(15);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    // open_close + clear_pw while editing: abandon edit
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5555);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    // change pw, lockout, async reset with timer at 7
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hABCD);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    idle(12);
    async_rst();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] p;
      case ($urandom_range(0, 4))
        0: p = 16'h0000;
        1: p = 16'h1234;
        2: p = 16'h5555;
        3: p = 16'hFFFF;
        default: p = 16'($urandom);
      endcase
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, p);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
    end
    idle(1);
    repeat (2) @(posedge clk);
    #2;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d/%0d expected=0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
